shift_tx_ctrl: RTL

SHIFT_TX_CTRL -- requirements
Module: shift_tx_ctrl

---
 rtl/shift_tx_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/shift_tx_ctrl.sv
// rtl/shift_tx_ctrl.sv - sequencer driving a universal shift register to serialise words
module shift_tx_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             msb_first,
   input  logic [CNT_W-1:0] baud_div,
   input  logic             abort,
   output logic [2:0]       sr_ctrl,
   output logic [N-1:0]     sr_d,
   output logic             busy,
   output logic             done
);

   localparam int            BW   = $clog2(N);
   localparam logic [BW-1:0] LAST = BW'(N - 1);

   localparam logic [2:0] SR_HOLD  = 3'b000;
   localparam logic [2:0] SR_LEFT  = 3'b001;
   localparam logic [2:0] SR_RIGHT = 3'b010;
   localparam logic [2:0] SR_LOAD  = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     data_q, data_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [BW-1:0]    bit_q, bit_d;

   // Next-state: handshake, per-bit hold timing, bit counting and abort.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dir_d   = dir_q;
      div_d   = div_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               dir_d   = msb_first;
               div_d   = baud_div;
               state_d = S_LOAD;
            end
         end
         S_LOAD, S_SHIFT: begin
            // The load presents bit 0; each shift presents the next bit.
            bit_d = (state_q == S_LOAD) ? '0 : bit_q + BW'(1);
            cyc_d = '0;
            if (div_q != '0)
               state_d = S_HOLD;
            else if (bit_d < LAST)
               state_d = S_SHIFT;
            else
               state_d = S_DONE;
         end
         S_HOLD: begin
            if (cyc_q == div_q - CNT_W'(1)) begin
               cyc_d   = '0;
               state_d = (bit_q < LAST) ? S_SHIFT : S_DONE;
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // DONE is allowed to finish so its pulse is never swallowed.
      if (abort && (state_q == S_LOAD || state_q == S_HOLD || state_q == S_SHIFT)) begin
         state_d = S_IDLE;
         cyc_d   = '0;
      end
   end

   // State and latched transfer parameters, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         dir_q   <= 1'b0;
         div_q   <= '0;
         cyc_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         div_q   <= div_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
      end
   end

   // Moore decode of the shift register command and fill data.
   always_comb begin
      sr_ctrl = SR_HOLD;
      sr_d    = '0;
      case (state_q)
         S_LOAD: begin
            sr_ctrl = SR_LOAD;
            sr_d    = data_q;
         end
         S_SHIFT: begin
            sr_ctrl = dir_q ? SR_LEFT : SR_RIGHT;
         end
         default: begin
            sr_ctrl = SR_HOLD;
         end
      endcase
   end

   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);

endmodule
